// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state enum, forward-select codes and REG_AW.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX operand forwarding select (EX/MEM beats MEM/WB, x0 never forwards).
// In: EX source regs, EX/MEM and MEM/WB dest + regwrite. Out: fwd_a, fwd_b.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] id_ex_rs1,
  input  logic [AW-1:0] id_ex_rs2,
  input  logic [AW-1:0] ex_mem_rd,
  input  logic          ex_mem_regwrite,
  input  logic [AW-1:0] mem_wb_rd,
  input  logic          mem_wb_regwrite,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  function automatic logic [1:0] sel(input logic [AW-1:0] rs,
                                     input logic [AW-1:0] m_rd,
                                     input logic          m_we,
                                     input logic [AW-1:0] w_rd,
                                     input logic          w_we);
    logic [1:0] s;
    s = FWD_RF;
    if (m_we && m_rd != '0 && m_rd == rs)
      s = FWD_MEM;
    else if (w_we && w_rd != '0 && w_rd == rs)
      s = FWD_WB;
    return s;
  endfunction

  always_comb begin
    fwd_a = sel(id_ex_rs1, ex_mem_rd, ex_mem_regwrite,
                mem_wb_rd, mem_wb_regwrite);
    fwd_b = sel(id_ex_rs2, ex_mem_rd, ex_mem_regwrite,
                mem_wb_rd, mem_wb_regwrite);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: mem-wait stall with timeout, branch
// flush, load-use/RAW stall, operand forwarding (FORWARDING_EN macro).
// Ports: clk, rst (sync, active-low); ID/EX/MEM/WB hazard inputs; mem_ready;
// stage enables, stage flushes, fwd_a/fwd_b, sticky mem_timeout_err.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int REG_AW       = pipe_ctrl_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_ex_rs1,
  input  logic [REG_AW-1:0] id_ex_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_memread,
  input  logic              id_ex_regwrite,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_regwrite,
  input  logic              ex_mem_memread,
  input  logic              ex_mem_memwrite,
  input  logic              ex_mem_pc_src,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_regwrite,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_timeout_err
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_wait;
  logic          stall;

  // Producer rd (written when we=1) is needed by an ID source register.
  function automatic logic id_hit(input logic [REG_AW-1:0] rd,
                                  input logic              we);
    return we && rd != '0 && (rd == id_rs1 || rd == id_rs2);
  endfunction

`ifdef FORWARDING_EN
  logic [1:0] fwd_a_raw, fwd_b_raw;

  pipe_fwd_unit #(.AW(REG_AW)) u_fwd (
    .id_ex_rs1       (id_ex_rs1),
    .id_ex_rs2       (id_ex_rs2),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .fwd_a           (fwd_a_raw),
    .fwd_b           (fwd_b_raw)
  );

  assign fwd_a = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst ? fwd_b_raw : FWD_RF;
  assign stall = id_hit(id_ex_rd, id_ex_memread);
`else
  logic fwd_unused;

  assign fwd_unused = ^{id_ex_rs1, id_ex_rs2, mem_wb_rd, mem_wb_regwrite};
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
  // Write-first regfile: a MEM/WB producer never needs a stall.
  assign stall = id_hit(id_ex_rd, id_ex_memread)
               | id_hit(id_ex_rd, id_ex_regwrite)
               | id_hit(ex_mem_rd, ex_mem_regwrite);
`endif

  assign mem_wait = (ex_mem_memread | ex_mem_memwrite) & ~mem_ready
                  & (state_q != ERR);

  assign mem_timeout_err = rst & (state_q == ERR);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst || state_q == ERR) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
      if (!rst) begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    end else if (mem_wait) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      mem_wb_flush = 1'b1;
      if (wait_cnt_q == CW'(MEM_WAIT_MAX - 1)) begin
        state_d = ERR;
      end else begin
        state_d    = MEM_WAIT;
        wait_cnt_d = wait_cnt_q + CW'(1);
      end
    end else begin
      // A branch held back by a mem-wait is served here, on mem_ready.
      state_d    = RUN;
      wait_cnt_d = '0;
      if (ex_mem_pc_src) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (scoreboard of expected outputs).
// Works with and without FORWARDING_EN.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int MAXW = 15;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {en[4], flush[4], fwd_a, fwd_b, err}
  localparam logic [12:0] NORM  = 13'b1111_0000_00_00_0;
  localparam logic [12:0] STALL = 13'b0011_0100_00_00_0;
  localparam logic [12:0] MWAIT = 13'b0000_0001_00_00_0;
  localparam logic [12:0] BR    = 13'b1111_1110_00_00_0;
  localparam logic [12:0] ERRV  = 13'b0000_1111_00_00_1;
  localparam logic [12:0] RSTV  = 13'b0000_1111_00_00_0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [AW-1:0] ex_mem_rd, mem_wb_rd;
  logic id_ex_memread, id_ex_regwrite, ex_mem_regwrite, ex_mem_memread;
  logic ex_mem_memwrite, ex_mem_pc_src, mem_wb_regwrite, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic mem_timeout_err;
  logic [12:0] obs;

  int tests = 0;
  int fails = 0;
  logic [12:0] sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_WAIT_MAX(MAXW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_pc_src(ex_mem_pc_src),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout_err(mem_timeout_err)
  );

  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                fwd_a, fwd_b, mem_timeout_err};

  function automatic logic [12:0] with_fwd(input logic [12:0] base,
                                           input logic [1:0] fa,
                                           input logic [1:0] fb);
    return base | {8'b0, fa, fb, 1'b0};
  endfunction

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_ex_rs1 = '0; id_ex_rs2 = '0;
    id_ex_rd = '0; ex_mem_rd = '0; mem_wb_rd = '0;
    id_ex_memread = 0; id_ex_regwrite = 0; ex_mem_regwrite = 0;
    ex_mem_memread = 0; ex_mem_memwrite = 0; ex_mem_pc_src = 0;
    mem_wb_regwrite = 0; mem_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    for (int i = 0; i < 3; i++) begin
      tick();
      rst = 0;
      ex_mem_memread = 1; mem_ready = 0; ex_mem_pc_src = 1;
      id_ex_memread = 1; id_ex_rd = 5'd4; id_rs1 = 5'd4;
      sb.push_back(RSTV);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset cyc%0d got=%b exp=%b", i, obs, e);
      end
    end
    tests++;
    if (dut.state_q !== RUN || dut.wait_cnt_q !== 4'd0) begin
      fails++;
      $display("FAIL reset_state got=%0d/%0d exp=0/0",
               dut.state_q, dut.wait_cnt_q);
    end
    tick();
    idle(); rst = 1;
    sb.push_back(NORM);
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_release got=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_load_use();
    logic [12:0] e;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      case (i)
        0: begin
          id_ex_memread = 1; id_ex_rd = 5'd5; id_rs2 = 5'd5;
          sb.push_back(STALL);
        end
        1: begin
          id_rs2 = 5'd5;
          sb.push_back(NORM);
        end
        default: begin
          id_ex_memread = 1; id_ex_rd = '0; id_rs1 = '0;
          sb.push_back(NORM);
        end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL load_use cyc%0d got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_forward();
    logic [12:0] e;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      ex_mem_regwrite = 1; mem_wb_regwrite = 1;
      ex_mem_rd = 5'd3; mem_wb_rd = 5'd3;
      case (i)
        0: begin
          id_ex_rs1 = 5'd3;
          sb.push_back(with_fwd(NORM, FWD ? FWD_MEM : FWD_RF, FWD_RF));
        end
        1: begin
          id_ex_rs1 = 5'd3; ex_mem_rd = '0;
          sb.push_back(with_fwd(NORM, FWD ? FWD_WB : FWD_RF, FWD_RF));
        end
        2: begin
          id_ex_rs2 = 5'd3; ex_mem_rd = 5'd9; id_ex_rs1 = 5'd9;
          sb.push_back(with_fwd(NORM, FWD ? FWD_MEM : FWD_RF,
                                FWD ? FWD_WB : FWD_RF));
        end
        default: begin
          ex_mem_rd = '0; mem_wb_rd = '0;
          sb.push_back(NORM);
        end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL forward cyc%0d got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [12:0] e;
    for (int i = 0; i < 6; i++) begin
      tick();
      idle();
      if (i < 5) ex_mem_memread = 1;
      mem_ready = (i >= 4);
      sb.push_back(i < 4 ? MWAIT : NORM);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL mem_wait cyc%0d got=%b exp=%b", i, obs, e);
      end
      if (i == 4) begin
        tests++;
        if (dut.state_q !== MEM_WAIT || dut.wait_cnt_q !== 4'd4) begin
          fails++;
          $display("FAIL mem_wait_cnt got=%0d/%0d exp=1/4",
                   dut.state_q, dut.wait_cnt_q);
        end
      end
    end
    tests++;
    if (dut.state_q !== RUN || dut.wait_cnt_q !== 4'd0) begin
      fails++;
      $display("FAIL mem_wait_done got=%0d/%0d exp=0/0",
               dut.state_q, dut.wait_cnt_q);
    end
  endtask

  task automatic test_timeout();
    logic [12:0] e;
    for (int i = 0; i < MAXW + 5; i++) begin
      tick();
      idle();
      ex_mem_memwrite = 1;
      mem_ready = (i >= MAXW + 2);
      ex_mem_pc_src = (i == MAXW + 3);
      sb.push_back(i < MAXW ? MWAIT : ERRV);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL timeout cyc%0d got=%b exp=%b", i, obs, e);
      end
    end
    tick();
    idle(); rst = 0;
    sb.push_back(RSTV);
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL timeout_rst got=%b exp=%b", obs, e);
    end
    tick();
    rst = 1;
    sb.push_back(NORM);
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs !== e || dut.state_q !== RUN) begin
      fails++;
      $display("FAIL timeout_exit got=%b/%0d exp=%b/0",
               obs, dut.state_q, e);
    end
  endtask

  task automatic test_branch_wait();
    logic [12:0] e;
    for (int i = 0; i < 5; i++) begin
      tick();
      idle();
      ex_mem_pc_src = (i < 3) || (i == 4);
      ex_mem_memread = (i < 3);
      mem_ready = (i >= 2);
      case (i)
        0, 1: sb.push_back(MWAIT);
        2, 4: sb.push_back(BR);
        default: sb.push_back(NORM);
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL branch cyc%0d got=%b exp=%b", i, obs, e);
      end
    end
    tests++;
    if (dut.state_q !== RUN) begin
      fails++;
      $display("FAIL branch_state got=%0d exp=0", dut.state_q);
    end
  endtask

  task automatic test_raw_stall();
    logic [12:0] e;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      id_rs1 = 5'd7;
      case (i)
        0: begin id_ex_regwrite = 1; id_ex_rd = 5'd7; end
        1: begin ex_mem_regwrite = 1; ex_mem_rd = 5'd7; end
        default: begin mem_wb_regwrite = 1; mem_wb_rd = 5'd7; end
      endcase
      sb.push_back((!FWD && i < 2) ? STALL : NORM);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL raw cyc%0d got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [12:0] e;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      ex_mem_memread = (i < 2);
      mem_ready = 0;
      rst = (i != 1);
      case (i)
        0: sb.push_back(MWAIT);
        1: sb.push_back(RSTV);
        default: sb.push_back(NORM);
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL mid_reset cyc%0d got=%b exp=%b", i, obs, e);
      end
    end
    tests++;
    if (dut.state_q !== RUN || dut.wait_cnt_q !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset_state got=%0d/%0d exp=0/0",
               dut.state_q, dut.wait_cnt_q);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forward();
    test_mem_wait();
    test_timeout();
    test_branch_wait();
    test_raw_stall();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
